// File: rtl/subexp_lanes.sv
// subexp_lanes: per-lane y = exp(a - b) in fixed point, LANES elements per beat.
// A scalar b (normally the running max of a softmax vector) is shared by all lanes.
// The block is a 3-stage pipeline:
//   S1 subtracts and clamps. S2 converts to base 2. S3 applies the linear 2^-r
//   approximation, then does the integer shift and the underflow check.
// A single global enable (adv) moves every stage, and a/b are joined on entry.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   a/a_valid/a_last    input beat (lane i at [i*IN_W +: IN_W]), a_ready handshake
//   b/b_valid           shared subtrahend, b_ready handshake
//   subexp/_valid/_last output beat (lane i at [i*OUT_W +: OUT_W]), Q1.(OUT_W-1)
//   next_ready          downstream ready
module subexp_lanes #(
    parameter int unsigned LANES   = 4,
    parameter int unsigned IN_W    = 16,
    parameter int unsigned FRAC_IN = 8,
    parameter int unsigned OUT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LANES*IN_W-1:0]  a,
    input  logic                   a_valid,
    input  logic                   a_last,
    output logic                   a_ready,
    input  logic [IN_W-1:0]        b,
    input  logic                   b_valid,
    output logic                   b_ready,
    output logic [LANES*OUT_W-1:0] subexp,
    output logic                   subexp_valid,
    output logic                   subexp_last,
    input  logic                   next_ready
);
    localparam int unsigned NW = IN_W + 1;     // |a - b| width
    localparam int unsigned TW = NW + 15;      // product width
    localparam int unsigned FB = FRAC_IN + 14; // fractional bits of the product
    localparam int unsigned KW = TW - FB;      // integer part width
    localparam int unsigned RW = OUT_W - 1;    // truncated fraction width
    localparam logic [14:0] LOG2E_Q14 = 15'd23637;
    localparam logic [OUT_W-1:0] ONE = {1'b1, {(OUT_W-1){1'b0}}};

    logic adv, fire;

    logic             s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic [NW-1:0]    n_q [LANES];
    logic [NW-1:0]    n_d [LANES];

    logic             s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
    logic [KW-1:0]    k_q [LANES];
    logic [KW-1:0]    k_d [LANES];
    logic [RW-1:0]    rt_q [LANES];
    logic [RW-1:0]    rt_d [LANES];

    logic                   out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [LANES*OUT_W-1:0] subexp_q, subexp_d;

    assign adv     = ~out_valid_q | next_ready;
    assign a_ready = rst_n & b_valid & adv;
    assign b_ready = rst_n & a_valid & adv;
    // a and b are only ever consumed together
    assign fire    = rst_n & a_valid & b_valid & adv;

    // Stage 1: n = max(b - a, 0)
    always_comb begin
        logic [NW-1:0] d;
        s1_valid_d = adv ? fire : s1_valid_q;
        s1_last_d  = adv ? a_last : s1_last_q;
        for (int i = 0; i < LANES; i++) begin
            d = {a[i*IN_W+IN_W-1], a[i*IN_W +: IN_W]} - {b[IN_W-1], b};
            // positive differences clamp to zero, negatives are negated
            n_d[i] = adv ? (d[NW-1] ? (~d + 1'b1) : '0) : n_q[i];
        end
    end

    // Stage 2: t = n * log2(e); split into integer k and truncated fraction rt
    always_comb begin
        logic [TW-1:0] t;
        s2_valid_d = adv ? s1_valid_q : s2_valid_q;
        s2_last_d  = adv ? s1_last_q : s2_last_q;
        for (int i = 0; i < LANES; i++) begin
            t = TW'(n_q[i]) * TW'(LOG2E_Q14);
            k_d[i]  = adv ? KW'(t >> FB) : k_q[i];
            rt_d[i] = adv ? RW'(t[FB-1:0] >> (FB - RW)) : rt_q[i];
        end
    end

    // Stage 3: 2^-(k+r) ~= (1 - r/2) >> k, zero once k shifts everything out
    always_comb begin
        logic [OUT_W-1:0] half;
        logic [OUT_W-1:0] m;
        out_valid_d = adv ? s2_valid_q : out_valid_q;
        out_last_d  = adv ? s2_last_q : out_last_q;
        subexp_d    = subexp_q;
        for (int i = 0; i < LANES; i++) begin
            half = {1'b0, rt_q[i]} >> 1;
            m    = ONE - half;
            if (adv) begin
                subexp_d[i*OUT_W +: OUT_W] =
                    (32'(k_q[i]) >= 32'(OUT_W)) ? '0 : (m >> k_q[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            subexp_q    <= '0;
            for (int i = 0; i < LANES; i++) begin
                n_q[i]  <= '0;
                k_q[i]  <= '0;
                rt_q[i] <= '0;
            end
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            subexp_q    <= subexp_d;
            for (int i = 0; i < LANES; i++) begin
                n_q[i]  <= n_d[i];
                k_q[i]  <= k_d[i];
                rt_q[i] <= rt_d[i];
            end
        end
    end

    assign subexp       = subexp_q;
    assign subexp_valid = out_valid_q;
    assign subexp_last  = out_last_q;

endmodule

// File: tb/tb_subexp_lanes.sv
// Self-checking bench for subexp_lanes with default parameters.
// The reference computes each lane's value arithmetically from a and b.
// Beat timing is tracked as a 3-deep queue that advances on the global enable.
module tb_subexp_lanes;
    localparam int LANES = 4;
    localparam int IN_W = 16;
    localparam int FRAC_IN = 8;
    localparam int OUT_W = 16;
    localparam int FB = FRAC_IN + 14;
    localparam int AW = LANES * IN_W;
    localparam int DW = LANES * OUT_W;

    logic clk = 1'b0;
    logic rst_n;
    logic [AW-1:0] a;
    logic a_valid, a_last, a_ready;
    logic [IN_W-1:0] b;
    logic b_valid, b_ready;
    logic [DW-1:0] subexp;
    logic subexp_valid, subexp_last;
    logic next_ready;

    subexp_lanes #(
        .LANES(LANES), .IN_W(IN_W), .FRAC_IN(FRAC_IN), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .a(a), .a_valid(a_valid), .a_last(a_last), .a_ready(a_ready),
        .b(b), .b_valid(b_valid), .b_ready(b_ready),
        .subexp(subexp), .subexp_valid(subexp_valid), .subexp_last(subexp_last),
        .next_ready(next_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        bit l;
        logic [DW-1:0] y;
    } slot_t;

    slot_t pipe[3];
    logic [DW-1:0] exp_y;
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_acc = 0;
    int first_acc = -1;
    int first_out = -1;
    int acc0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [OUT_W-1:0] lane_ref(input longint av, input longint bv);
        longint d, n, t, k, r, rt, m;
        d = av - bv;
        if (d > 0) d = 0;
        n = -d;
        t = n * 23637;
        k = t / (64'sd1 << FB);
        r = t % (64'sd1 << FB);
        rt = r / (64'sd1 << (FB - OUT_W + 1));
        m = (64'sd1 << (OUT_W - 1)) - rt / 2;
        if (k >= OUT_W) return '0;
        return OUT_W'(m / (64'sd1 << k));
    endfunction

    function automatic logic [DW-1:0] beat_ref(input logic [AW-1:0] av, input logic [IN_W-1:0] bv);
        logic [DW-1:0] y;
        logic [IN_W-1:0] al;
        y = '0;
        for (int i = 0; i < LANES; i++) begin
            al = av[i*IN_W +: IN_W];
            y[i*OUT_W +: OUT_W] = lane_ref(longint'($signed(al)), longint'($signed(bv)));
        end
        return y;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 3; i++) pipe[i] = '{v: 1'b0, l: 1'b0, y: '0};
    endtask

    // One clock: check outputs at negedge, then advance the model at posedge.
    task automatic cycle();
        bit exp_adv, exp_rdy, fire;
        @(negedge clk);
        cyc++;
        exp_adv = !pipe[2].v || next_ready;
        exp_rdy = rst_n && exp_adv;
        chk("a_ready", 64'(a_ready), 64'(exp_rdy && b_valid));
        chk("b_ready", 64'(b_ready), 64'(exp_rdy && a_valid));
        chk("subexp_valid", 64'(subexp_valid), 64'(pipe[2].v));
        if (pipe[2].v) begin
            chk("subexp", 64'(subexp), 64'(pipe[2].y));
            chk("subexp_last", 64'(subexp_last), 64'(pipe[2].l));
            if (first_out < 0) first_out = cyc;
        end
        fire = exp_rdy && a_valid && b_valid;
        if (fire) begin
            n_acc++;
            if (first_acc < 0) first_acc = cyc;
        end
        @(posedge clk);
        if (!rst_n) begin
            clear_model();
        end else if (exp_adv) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = '{v: fire, l: a_last, y: exp_y};
        end
        #1;
    endtask

    task automatic drive(input logic [AW-1:0] av, input logic [IN_W-1:0] bv,
                         input bit avl, input bit bvl, input bit last);
        a = av;
        b = bv;
        a_valid = avl;
        b_valid = bvl;
        a_last = last;
        exp_y = beat_ref(av, bv);
    endtask

    function automatic logic [AW-1:0] rand_a(input logic [IN_W-1:0] bv);
        logic [AW-1:0] av;
        for (int i = 0; i < LANES; i++)
            av[i*IN_W +: IN_W] = bv - IN_W'($urandom_range(0, 16'h0A00)) + IN_W'($urandom_range(0, 16'h40));
        return av;
    endfunction

    initial begin
        logic [IN_W-1:0] rb;
        clear_model();
        rst_n = 1'b0;
        next_ready = 1'b1;
        drive('0, '0, 1'b1, 1'b1, 1'b0);
        #1;
        // Reset state: outputs zero, no readiness
        chk("rst_subexp", 64'(subexp), 64'd0);
        chk("rst_last", 64'(subexp_last), 64'd0);
        cycle();
        cycle();
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cycle();

        // Identity and clamp (directed constant expectation)
        drive({16'h7FFF, 16'h0200, 16'h0000, 16'h0100}, 16'h0100, 1'b1, 1'b1, 1'b0);
        exp_y = {16'h8000, 16'h8000, 16'h31D5, 16'h8000};
        cycle();
        // Approximation and underflow
        drive({16'h8000, 16'hF000, 16'hFE00, 16'hFF00}, 16'h0000, 1'b1, 1'b1, 1'b1);
        exp_y = {16'h0000, 16'h0000, 16'h11D5, 16'h31D5};
        cycle();
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        repeat (4) cycle();

        // 8 back-to-back beats, last on beat 8, latency check
        first_acc = -1;
        first_out = -1;
        rb = IN_W'($urandom);
        for (int i = 0; i < 8; i++) begin
            drive(rand_a(rb), rb, 1'b1, 1'b1, i == 7);
            cycle();
        end
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        repeat (4) cycle();
        chk("latency", 64'(first_out - first_acc), 64'd3);

        // Backpressure: fill the pipe, hold next_ready low for 5 cycles
        next_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rb = IN_W'($urandom);
            drive(rand_a(rb), rb, 1'b1, 1'b1, i[0]);
            cycle();
        end
        next_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rb = IN_W'($urandom);
            drive(rand_a(rb), rb, 1'b1, 1'b1, 1'b0);
            cycle();
        end
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        repeat (4) cycle();

        // Join: a alone for 4 cycles, then b arrives for one cycle
        acc0 = n_acc;
        rb = 16'h0100;
        drive(rand_a(rb), rb, 1'b1, 1'b0, 1'b1);
        repeat (4) cycle();
        chk("join_none", 64'(n_acc - acc0), 64'd0);
        drive(a, rb, 1'b1, 1'b1, 1'b1);
        cycle();
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        repeat (4) cycle();
        chk("join_one", 64'(n_acc - acc0), 64'd1);

        // Reset with 3 beats in flight
        for (int i = 0; i < 3; i++) begin
            rb = IN_W'($urandom);
            drive(rand_a(rb), rb, 1'b1, 1'b1, 1'b0);
            cycle();
        end
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(subexp_valid), 64'd0);
        clear_model();
        cycle();
        rst_n = 1'b1;
        repeat (5) cycle();

        // Random traffic and backpressure
        for (int i = 0; i < 300; i++) begin
            rb = IN_W'($urandom);
            next_ready = ($urandom_range(0, 3) != 0);
            drive(rand_a(rb), rb, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  1'($urandom));
            cycle();
        end
        next_ready = 1'b1;
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
